// File: rtl/ghost_pkg.sv
// Shared ghost/map definitions: map geometry, home tile, direction and state encodings.
package ghost_pkg;

  localparam int unsigned MAP_W               = 10;
  localparam int unsigned MAP_H               = 9;
  localparam int unsigned MAP_CELLS           = MAP_W * MAP_H;
  localparam int unsigned COORD_W             = 5;
  localparam int unsigned DIR_W               = 2;
  localparam int unsigned IDX_W               = 7;
  localparam int unsigned HOLD_W              = 4;
  localparam int unsigned GHOST_HOME_X        = 8;
  localparam int unsigned GHOST_HOME_Y        = 1;
  localparam int unsigned GHOST_RESPAWN_STEPS = 8;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic {
    ST_ROAM = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pos_t;

endpackage

// File: rtl/map_cell_query.sv
// Combinational neighbour lookup: target tile for a direction, its validity and wall bit.
// Ports:
//   map   - wall map, bit y*MAP_W+x, 1 = wall
//   x, y  - current tile
//   dir   - requested direction (up/down/left/right)
//   tx,ty - target tile (horizontal tunnel wrap applied)
//   valid - target is inside the vertical bounds
//   wall  - target cell is a wall (0 when not valid)
module map_cell_query #(
  parameter int unsigned MAP_W = ghost_pkg::MAP_W,
  parameter int unsigned MAP_H = ghost_pkg::MAP_H
) (
  input  logic [0:MAP_W*MAP_H-1]        map,
  input  logic [ghost_pkg::COORD_W-1:0] x,
  input  logic [ghost_pkg::COORD_W-1:0] y,
  input  logic [ghost_pkg::DIR_W-1:0]   dir,
  output logic [ghost_pkg::COORD_W-1:0] tx,
  output logic [ghost_pkg::COORD_W-1:0] ty,
  output logic                          valid,
  output logic                          wall
);
  import ghost_pkg::*;

  logic [IDX_W-1:0] idx;

  // Target selection; wrap decided by explicit compare, never by overflow.
  always_comb begin
    tx    = x;
    ty    = y;
    valid = 1'b1;
    idx   = '0;
    wall  = 1'b0;
    case (dir)
      DIR_UP: begin
        if (y == 5'd0) valid = 1'b0;
        else           ty    = y - 5'd1;
      end
      DIR_DOWN: begin
        if (y == 5'(MAP_H - 1)) valid = 1'b0;
        else                    ty    = y + 5'd1;
      end
      DIR_LEFT: begin
        tx = (x == 5'd0) ? 5'(MAP_W - 1) : x - 5'd1;
      end
      default: begin
        tx = (x == 5'(MAP_W - 1)) ? 5'd0 : x + 5'd1;
      end
    endcase
    // Index only formed for in-bounds targets so it never leaves 0..MAP_W*MAP_H-1.
    if (valid) begin
      idx  = 7'(ty) * 7'(MAP_W) + 7'(tx);
      wall = map[idx];
    end
  end

endmodule

// File: rtl/ghost_mover.sv
// Ghost position tracker: moves one tile per step tick, honours walls and the
// side tunnel, and parks an eaten ghost at home for RESPAWN_STEPS ticks.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   step_lvl    - game-rate level; each rising edge is one step
//   dir         - requested direction from the direction controller
//   map         - wall map, bit y*MAP_W+x, 1 = wall
//   eaten       - single-cycle pulse: ghost was eaten
//   ghost_x/y   - current tile
//   prev_dir    - direction of the last successful move
//   moved       - one-cycle pulse on a successful move
//   blocked     - sticky: last step attempt hit a wall or vertical boundary
//   at_home     - high while parked at home
module ghost_mover #(
  parameter int unsigned MAP_W         = ghost_pkg::MAP_W,
  parameter int unsigned MAP_H         = ghost_pkg::MAP_H,
  parameter int unsigned HOME_X        = ghost_pkg::GHOST_HOME_X,
  parameter int unsigned HOME_Y        = ghost_pkg::GHOST_HOME_Y,
  parameter int unsigned RESPAWN_STEPS = ghost_pkg::GHOST_RESPAWN_STEPS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          step_lvl,
  input  logic [ghost_pkg::DIR_W-1:0]   dir,
  input  logic [0:MAP_W*MAP_H-1]        map,
  input  logic                          eaten,
  output logic [ghost_pkg::COORD_W-1:0] ghost_x,
  output logic [ghost_pkg::COORD_W-1:0] ghost_y,
  output logic [ghost_pkg::DIR_W-1:0]   prev_dir,
  output logic                          moved,
  output logic                          blocked,
  output logic                          at_home
);
  import ghost_pkg::*;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  pos_t                pos_q, pos_d;
  logic [DIR_W-1:0]    prev_dir_q, prev_dir_d;
  logic                moved_q, moved_d;
  logic                blocked_q, blocked_d;
  logic                at_home_q, at_home_d;
  logic                step_q;
  logic                step_c;

  logic [COORD_W-1:0]  tx_c, ty_c;
  logic                valid_c, wall_c;
  pos_t                home_c;

  assign home_c = '{x: 5'(HOME_X), y: 5'(HOME_Y)};

  // Rising edge of the step level; acted on at the edge where step_q captures 1.
  assign step_c = step_lvl & ~step_q;

  map_cell_query #(
    .MAP_W (MAP_W),
    .MAP_H (MAP_H)
  ) u_query (
    .map   (map),
    .x     (pos_q.x),
    .y     (pos_q.y),
    .dir   (dir),
    .tx    (tx_c),
    .ty    (ty_c),
    .valid (valid_c),
    .wall  (wall_c)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ROAM;
      hold_cnt_q <= '0;
      pos_q      <= '{x: 5'(HOME_X), y: 5'(HOME_Y)};
      prev_dir_q <= DIR_UP;
      moved_q    <= 1'b0;
      blocked_q  <= 1'b0;
      at_home_q  <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      pos_q      <= pos_d;
      prev_dir_q <= prev_dir_d;
      moved_q    <= moved_d;
      blocked_q  <= blocked_d;
      at_home_q  <= at_home_d;
      step_q     <= step_lvl;
    end
  end

  // Next-state logic; eaten overrides any step in the same cycle.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    pos_d      = pos_q;
    prev_dir_d = prev_dir_q;
    moved_d    = 1'b0;
    blocked_d  = blocked_q;
    at_home_d  = at_home_q;
    if (eaten) begin
      state_d    = ST_HOLD;
      pos_d      = home_c;
      hold_cnt_d = '0;
      at_home_d  = 1'b1;
      blocked_d  = 1'b0;
    end else if (step_c) begin
      case (state_q)
        ST_ROAM: begin
          if (valid_c && !wall_c) begin
            pos_d      = '{x: tx_c, y: ty_c};
            prev_dir_d = dir;
            moved_d    = 1'b1;
            blocked_d  = 1'b0;
          end else begin
            blocked_d  = 1'b1;
          end
        end
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_W'(RESPAWN_STEPS - 1)) begin
            state_d    = ST_ROAM;
            at_home_d  = 1'b0;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 4'd1;
          end
        end
        default: state_d = ST_ROAM;
      endcase
    end
  end

  assign ghost_x  = pos_q.x;
  assign ghost_y  = pos_q.y;
  assign prev_dir = prev_dir_q;
  assign moved    = moved_q;
  assign blocked  = blocked_q;
  assign at_home  = at_home_q;

endmodule

// File: tb/tb_ghost_mover.sv
// Directed bench for ghost_mover: reset, tunnel wrap, walls, boundaries, eaten/hold.
module tb_ghost_mover;

  logic        clk;
  logic        rst_n;
  logic        step_lvl;
  logic [1:0]  dir;
  logic [0:89] map_r;
  logic        eaten;
  logic [4:0]  ghost_x;
  logic [4:0]  ghost_y;
  logic [1:0]  prev_dir;
  logic        moved;
  logic        blocked;
  logic        at_home;

  int vec;
  int err;

  ghost_mover dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .step_lvl (step_lvl),
    .dir      (dir),
    .map      (map_r),
    .eaten    (eaten),
    .ghost_x  (ghost_x),
    .ghost_y  (ghost_y),
    .prev_dir (prev_dir),
    .moved    (moved),
    .blocked  (blocked),
    .at_home  (at_home)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n    = 1'b0;
    step_lvl = 1'b0;
    eaten    = 1'b0;
    dir      = 2'b00;
    map_r    = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One step tick; mv is the moved output one edge after step_lvl rises.
  task automatic do_step(input logic [1:0] d, output logic mv);
    @(negedge clk);
    dir      = d;
    step_lvl = 1'b1;
    @(negedge clk);
    mv       = moved;
    step_lvl = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    vec++;
    if ({ghost_x, ghost_y} !== {5'd8, 5'd1}) begin
      err++; $display("FAIL reset_pos got %0d,%0d want 8,1", ghost_x, ghost_y);
    end
    vec++;
    if ({prev_dir, moved, blocked, at_home} !== 5'b00_000) begin
      err++; $display("FAIL reset_flags got pd=%b mv=%b bl=%b ah=%b want 00 0 0 0",
                      prev_dir, moved, blocked, at_home);
    end
  endtask

  task automatic test_wrap();
    logic mv;
    int   pulses;
    logic [4:0] exp_x [3];
    exp_x[0] = 5'd9; exp_x[1] = 5'd0; exp_x[2] = 5'd1;
    apply_reset();
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      do_step(2'b11, mv);
      if (mv === 1'b1) pulses++;
      vec++;
      if ({ghost_x, ghost_y} !== {exp_x[i], 5'd1}) begin
        err++; $display("FAIL wrap_right[%0d] got %0d,%0d want %0d,1", i, ghost_x, ghost_y, exp_x[i]);
      end
    end
    vec++;
    if (pulses != 3) begin
      err++; $display("FAIL wrap_pulses got %0d want 3", pulses);
    end
    vec++;
    if (prev_dir !== 2'b11 || moved !== 1'b0) begin
      err++; $display("FAIL wrap_prev got pd=%b mv=%b want 11 0", prev_dir, moved);
    end
    // Left through the tunnel: 1 -> 0 -> 9.
    do_step(2'b10, mv);
    do_step(2'b10, mv);
    vec++;
    if ({ghost_x, ghost_y, prev_dir, mv} !== {5'd9, 5'd1, 2'b10, 1'b1}) begin
      err++; $display("FAIL wrap_left got %0d,%0d pd=%b mv=%b want 9,1 10 1", ghost_x, ghost_y, prev_dir, mv);
    end
  endtask

  task automatic test_wall();
    logic mv;
    apply_reset();
    map_r[28] = 1'b1;
    do_step(2'b01, mv);
    vec++;
    if ({ghost_x, ghost_y, blocked, mv} !== {5'd8, 5'd1, 1'b1, 1'b0}) begin
      err++; $display("FAIL wall_hit got %0d,%0d bl=%b mv=%b want 8,1 1 0", ghost_x, ghost_y, blocked, mv);
    end
    do_step(2'b00, mv);
    vec++;
    if ({ghost_x, ghost_y, blocked, mv} !== {5'd8, 5'd0, 1'b0, 1'b1}) begin
      err++; $display("FAIL wall_escape got %0d,%0d bl=%b mv=%b want 8,0 0 1", ghost_x, ghost_y, blocked, mv);
    end
    map_r[28] = 1'b0;
  endtask

  task automatic test_bounds();
    logic mv;
    // Continue from (8,0): five lefts to (3,0), then up is out of bounds.
    for (int i = 0; i < 5; i++) do_step(2'b10, mv);
    vec++;
    if ({ghost_x, ghost_y} !== {5'd3, 5'd0}) begin
      err++; $display("FAIL bounds_setup got %0d,%0d want 3,0", ghost_x, ghost_y);
    end
    do_step(2'b00, mv);
    vec++;
    if ({ghost_x, ghost_y, blocked, mv, prev_dir} !== {5'd3, 5'd0, 1'b1, 1'b0, 2'b10}) begin
      err++; $display("FAIL bounds_top got %0d,%0d bl=%b mv=%b pd=%b want 3,0 1 0 10",
                      ghost_x, ghost_y, blocked, mv, prev_dir);
    end
    apply_reset();
    for (int i = 0; i < 7; i++) do_step(2'b01, mv);
    do_step(2'b01, mv);
    vec++;
    if ({ghost_x, ghost_y, blocked, mv} !== {5'd8, 5'd8, 1'b1, 1'b0}) begin
      err++; $display("FAIL bounds_bottom got %0d,%0d bl=%b mv=%b want 8,8 1 0", ghost_x, ghost_y, blocked, mv);
    end
  endtask

  task automatic test_eaten();
    logic mv;
    apply_reset();
    for (int i = 0; i < 4; i++) do_step(2'b01, mv);
    for (int i = 0; i < 3; i++) do_step(2'b10, mv);
    vec++;
    if ({ghost_x, ghost_y} !== {5'd5, 5'd5}) begin
      err++; $display("FAIL eaten_setup got %0d,%0d want 5,5", ghost_x, ghost_y);
    end
    // Eaten and step edge in the same cycle.
    @(negedge clk);
    dir      = 2'b00;
    eaten    = 1'b1;
    step_lvl = 1'b1;
    @(negedge clk);
    eaten = 1'b0;
    vec++;
    if ({ghost_x, ghost_y, at_home, moved, blocked, prev_dir} !== {5'd8, 5'd1, 1'b1, 1'b0, 1'b0, 2'b10}) begin
      err++; $display("FAIL eaten_same got %0d,%0d ah=%b mv=%b bl=%b pd=%b want 8,1 1 0 0 10",
                      ghost_x, ghost_y, at_home, moved, blocked, prev_dir);
    end
    step_lvl = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 7; i++) begin
      do_step(2'b00, mv);
      vec++;
      if ({at_home, mv, ghost_x, ghost_y} !== {1'b1, 1'b0, 5'd8, 5'd1}) begin
        err++; $display("FAIL hold_step[%0d] got ah=%b mv=%b %0d,%0d want 1 0 8,1", i, at_home, mv, ghost_x, ghost_y);
      end
    end
    do_step(2'b00, mv);
    vec++;
    if ({at_home, mv, ghost_x, ghost_y} !== {1'b0, 1'b0, 5'd8, 5'd1}) begin
      err++; $display("FAIL hold_release got ah=%b mv=%b %0d,%0d want 0 0 8,1", at_home, mv, ghost_x, ghost_y);
    end
    do_step(2'b10, mv);
    vec++;
    if ({mv, ghost_x, ghost_y, prev_dir} !== {1'b1, 5'd7, 5'd1, 2'b10}) begin
      err++; $display("FAIL first_roam got mv=%b %0d,%0d pd=%b want 1 7,1 10", mv, ghost_x, ghost_y, prev_dir);
    end
  endtask

  task automatic test_rehold();
    logic mv;
    apply_reset();
    @(negedge clk); eaten = 1'b1;
    @(negedge clk); eaten = 1'b0;
    vec++;
    if (at_home !== 1'b1) begin
      err++; $display("FAIL rehold_enter got ah=%b want 1", at_home);
    end
    for (int i = 0; i < 5; i++) do_step(2'b11, mv);
    @(negedge clk); eaten = 1'b1;
    @(negedge clk); eaten = 1'b0;
    for (int i = 0; i < 7; i++) do_step(2'b11, mv);
    vec++;
    if (at_home !== 1'b1) begin
      err++; $display("FAIL rehold_7 got ah=%b want 1", at_home);
    end
    do_step(2'b11, mv);
    vec++;
    if (at_home !== 1'b0) begin
      err++; $display("FAIL rehold_8 got ah=%b want 0", at_home);
    end
    // Async reset while parked at home.
    do_step(2'b11, mv);
    @(negedge clk); eaten = 1'b1;
    @(negedge clk); eaten = 1'b0;
    for (int i = 0; i < 3; i++) do_step(2'b00, mv);
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if ({ghost_x, ghost_y, prev_dir, moved, blocked, at_home} !== {5'd8, 5'd1, 2'b00, 3'b000}) begin
      err++; $display("FAIL reset_mid_hold got %0d,%0d pd=%b mv=%b bl=%b ah=%b want 8,1 00 0 0 0",
                      ghost_x, ghost_y, prev_dir, moved, blocked, at_home);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_step(2'b00, mv);
    vec++;
    if ({mv, ghost_x, ghost_y, at_home} !== {1'b1, 5'd8, 5'd0, 1'b0}) begin
      err++; $display("FAIL after_reset_move got mv=%b %0d,%0d ah=%b want 1 8,0 0", mv, ghost_x, ghost_y, at_home);
    end
  endtask

  initial begin
    vec = 0;
    err = 0;
    rst_n    = 1'b0;
    step_lvl = 1'b0;
    eaten    = 1'b0;
    dir      = 2'b00;
    map_r    = '0;
    test_reset();
    test_wrap();
    test_wall();
    test_bounds();
    test_eaten();
    test_rehold();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
